// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on the memory-ready handshake, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int unsigned ALU_OP_WIDTH  = 3,
    parameter bit          MEM_WAIT_EN   = 1'b1,
    parameter int unsigned RET_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [5:0]               opcode_i,
    input  logic                     zero_i,
    input  logic                     mem_ready_i,
    output logic                     pc_write_o,
    output logic [1:0]               pc_src_o,
    output logic                     ir_write_o,
    output logic                     i_or_d_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic                     mem_to_reg_o,
    output logic                     reg_dst_o,
    output logic                     reg_write_o,
    output logic                     alu_src_a_o,
    output logic [1:0]               alu_src_b_o,
    output logic [ALU_OP_WIDTH-1:0]  alu_op_o,
    output logic                     instr_done_o,
    output logic                     illegal_op_o,
    output logic [3:0]               state_o,
    output logic [RET_CNT_WIDTH-1:0] ret_cnt_o
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_LOAD_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_TRAP      = 4'd10;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    logic [3:0]               state_q;
    logic [3:0]               state_d;
    logic [5:0]               opcode_r;
    logic                     illegal_q;
    logic [RET_CNT_WIDTH-1:0] ret_cnt_q;
    logic                     mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;

    assign mem_ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
        case (op)
            OP_R:    return 3'b111;
            OP_ADDI: return 3'b100;
            OP_ORI:  return 3'b101;
            OP_ANDI: return 3'b001;
            OP_LUI:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // DECODE dispatches on the live opcode; later states rely on opcode_r
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW:                           state_d = S_MEM_ADDR;
                    OP_R, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:                         state_d = S_BRANCH;
                    OP_J:                                   state_d = S_JUMP;
                    default:                                state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_r == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_LOAD_WB : S_MEM_READ;
            S_LOAD_WB:   state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b011;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b011;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = (opcode_r == OP_R) ? 2'b00 : 2'b10;
                alu_op    = exec_alu_op(opcode_r);
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode_r == OP_R);
                alu_op     = exec_alu_op(opcode_r);
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b010;
                pc_src     = 2'b01;
                pc_write   = ((opcode_r == OP_BEQ) & zero_i) | ((opcode_r == OP_BNE) & ~zero_i);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            opcode_r  <= '0;
            illegal_q <= 1'b0;
            ret_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_r <= opcode_i;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (instr_done) begin
                ret_cnt_q <= ret_cnt_q + RET_CNT_WIDTH'(1);
            end
        end
    end

    // Reset gates every output combinationally so a mid-instruction reset never writes
    assign pc_write_o   = pc_write & ~reset_i;
    assign pc_src_o     = reset_i ? 2'b00 : pc_src;
    assign ir_write_o   = ir_write & ~reset_i;
    assign i_or_d_o     = i_or_d & ~reset_i;
    assign mem_read_o   = mem_read & ~reset_i;
    assign mem_write_o  = mem_write & ~reset_i;
    assign mem_to_reg_o = mem_to_reg & ~reset_i;
    assign reg_dst_o    = reg_dst & ~reset_i;
    assign reg_write_o  = reg_write & ~reset_i;
    assign alu_src_a_o  = alu_src_a & ~reset_i;
    assign alu_src_b_o  = reset_i ? 2'b00 : alu_src_b;
    assign alu_op_o     = reset_i ? '0 : ALU_OP_WIDTH'(alu_op);
    assign instr_done_o = instr_done & ~reset_i;
    assign illegal_op_o = illegal_q & ~reset_i;
    assign state_o      = reset_i ? 4'd0 : state_q;
    assign ret_cnt_o    = reset_i ? '0 : ret_cnt_q;

endmodule
